multdiv_unit: RTL
=================

// Module: multdiv_unit
// PURPOSE
//  Iterative signed 32-bit multiplier/divider fed by the execute stage's startMult/startDiv strobes.
//  Latches operands and destination register, runs a fixed WIDTH-cycle shift/add or restoring
//  divide on magnitudes, then pulses multDivDone with result and exception flag.
//  Holds busy high while running so the pipeline control can stall fetch, decode and execute.
// PARAMETERS
//  WIDTH  32  operand/result width; also the iteration count. Counter is $clog2(WIDTH)+1 bits.
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  startMult    in   1      start signed multiply; sampled only when accepting
//  startDiv     in   1      start signed divide; sampled only when accepting
//  operandA     in   WIDTH  multiplicand / dividend
//  operandB     in   WIDTH  multiplier / divisor
//  destRegIn    in   5      destination register of the op; latched at start
//  busy         out  1      op in progress; the pipeline stalls while high
//  multDivDone  out  1      one-cycle pulse: result, exception and destRegOut valid
//  result       out  WIDTH  product low WIDTH bits or quotient; held until next accept
//  exception    out  1      overflow or divide-by-zero; held with result
//  destRegOut   out  5      latched destRegIn; held with result
// BEHAVIOUR
//  Reset: state=IDLE, count=0, busy=0, multDivDone=0, result=0, exception=0, destRegOut=0.
//   Reset mid-operation aborts the op; no done pulse for the aborted op.
//  FSM states:
//   IDLE: accepting.
//   MULT, DIV: busy=1. count increments 0..WIDTH-1.
//   DONE: multDivDone=1, busy=0, accepting.
//  Accept (IDLE or DONE): startMult -> MULT; else startDiv -> DIV; else -> IDLE.
//   startMult has priority when both are high.
//   Accept latches |A|, |B|, sign bits, destRegIn and the divide-by-zero flag (B==0); clears count.
//  Starts are ignored while in MULT or DIV; no queueing.
//  MULT/DIV -> DONE on the edge where count==WIDTH-1. result/exception/destRegOut register on that same edge.
//  Latency: start sampled at edge N -> busy high for cycles N+1..N+WIDTH -> multDivDone high for the
//   single cycle N+WIDTH+1 (cycle 33 after start for WIDTH=32). Back-to-back: start in DONE is accepted.
//  Multiply: unsigned shift-add of magnitudes into a 2*WIDTH product, negated if signA^signB.
//   result = P[WIDTH-1:0]. exception = 1 if P[2W-1:W-1] is not all 0s or all 1s.
//   Example: 0x40000000*2 -> result 0x80000000, exception 1.
//  Divide: restoring division of magnitudes, truncating toward zero.
//   Quotient is negated if signA^signB; the remainder is discarded.
//   B==0: result=0, exception=1, full latency still taken.
//   A=0x80000000, B=-1: result=0x80000000, exception=1.
//  Magnitude of 0x80000000 is computed as an unsigned WIDTH-bit 0x80000000; no internal overflow.
//  In IDLE the outputs result, exception and destRegOut retain their last values; multDivDone=0.
// TESTING
//  1. startMult, A=7, B=-6, dest=5 -> busy high 32 cycles; at cycle 33 multDivDone=1,
//     result=0xFFFFFFD6 (-42), exception=0, destRegOut=5.
//  2. startDiv, A=-43, B=5 -> result=0xFFFFFFF8 (-8), exception=0.
//     startDiv, A=100, B=0 -> result=0, exception=1, same latency.
//  3. startMult A=0x00010000, B=0x00010000 -> result=0, exception=1.
//     A=0x80000000, B=-1 (div) -> result=0x80000000, exception=1.
//  4. Pulse startDiv at cycle 10 of a running multiply -> ignored; only the multiply's done
//     pulse appears. New start in DONE cycle -> accepted, busy high next cycle.
//  5. reset at cycle 15 of a divide -> next cycle busy=0, result=0, no done pulse.
//     startMult and startDiv together -> multiply is performed.

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier/divider: WIDTH-cycle shift-add multiply or restoring divide on
// operand magnitudes, with a one-cycle done pulse carrying result, exception and destination.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             startMult,
    input  logic             startDiv,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [4:0]       destRegIn,
    output logic             busy,
    output logic             multDivDone,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [4:0]       destRegOut
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;        // product accumulator, or remainder in low bits
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   op_q, op_d;          // multiplier, or dividend shifting into quotient
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               neg_q, neg_d;
    logic               dbz_q, dbz_d;
    logic [4:0]         dest_q, dest_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic [4:0]         dest_out_q, dest_out_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               last;
    logic [2*WIDTH-1:0] prod_next, prod_signed;
    logic [WIDTH:0]     shifted, trial, rem_next;
    logic               ge;
    logic [WIDTH-1:0]   quo_next, quo_signed;
    logic               mul_exc, div_exc;

    always_comb begin
        mag_a = operandA[WIDTH-1] ? (~operandA + 1'b1) : operandA;
        mag_b = operandB[WIDTH-1] ? (~operandB + 1'b1) : operandB;
        last  = (count_q == CntW'(WIDTH - 1));

        prod_next   = acc_q + (op_q[0] ? mcand_q : '0);
        prod_signed = neg_q ? (~prod_next + 1'b1) : prod_next;
        // Product fits in WIDTH signed bits only if the top WIDTH+1 bits are a sign extension
        mul_exc     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));

        shifted    = {acc_q[WIDTH-1:0], op_q[WIDTH-1]};
        trial      = shifted - {1'b0, divisor_q};
        ge         = ~trial[WIDTH];
        rem_next   = ge ? trial : shifted;
        quo_next   = {op_q[WIDTH-2:0], ge};
        quo_signed = neg_q ? (~quo_next + 1'b1) : quo_next;
        // A positive quotient with the top bit set only arises from MIN / -1
        div_exc    = dbz_q || (!neg_q && quo_next[WIDTH-1]);
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        op_d       = op_q;
        divisor_d  = divisor_q;
        neg_d      = neg_q;
        dbz_d      = dbz_q;
        dest_d     = dest_q;
        result_d   = result_q;
        exc_d      = exc_q;
        dest_out_d = dest_out_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (startMult || startDiv) begin
                    state_d   = startMult ? StMult : StDiv;
                    count_d   = '0;
                    acc_d     = '0;
                    mcand_d   = (2*WIDTH)'(mag_a);
                    op_d      = startMult ? mag_b : mag_a;
                    divisor_d = mag_b;
                    neg_d     = operandA[WIDTH-1] ^ operandB[WIDTH-1];
                    dbz_d     = (operandB == '0);
                    dest_d    = destRegIn;
                end
            end
            StMult: begin
                acc_d   = prod_next;
                mcand_d = mcand_q << 1;
                op_d    = op_q >> 1;
                count_d = count_q + CntW'(1);
                if (last) begin
                    state_d    = StDone;
                    result_d   = prod_signed[WIDTH-1:0];
                    exc_d      = mul_exc;
                    dest_out_d = dest_q;
                end
            end
            StDiv: begin
                acc_d   = (2*WIDTH)'(rem_next);
                op_d    = quo_next;
                count_d = count_q + CntW'(1);
                if (last) begin
                    state_d    = StDone;
                    result_d   = dbz_q ? '0 : quo_signed;
                    exc_d      = div_exc;
                    dest_out_d = dest_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            op_q       <= '0;
            divisor_q  <= '0;
            neg_q      <= 1'b0;
            dbz_q      <= 1'b0;
            dest_q     <= '0;
            result_q   <= '0;
            exc_q      <= 1'b0;
            dest_out_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            op_q       <= op_d;
            divisor_q  <= divisor_d;
            neg_q      <= neg_d;
            dbz_q      <= dbz_d;
            dest_q     <= dest_d;
            result_q   <= result_d;
            exc_q      <= exc_d;
            dest_out_q <= dest_out_d;
        end
    end

    always_comb begin
        busy        = (state_q == StMult) || (state_q == StDiv);
        multDivDone = (state_q == StDone);
        result      = result_q;
        exception   = exc_q;
        destRegOut  = dest_out_q;
    end

endmodule
